alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Upstream issue/writeback stage for the 16-bit `alu`.
- Accepts one decoded instruction at a time (op, rd, ra, rb) over a valid/ready handshake.
- Reads operands from an internal 8x16 register file and drives the ALU's a/b/op/cf inputs.
- Waits the ALU latency, then writes acc back to rd, captures c into a HI register and latches the c/z/o flags; the latched carry feeds the ALU's cf input.

Parameters:
- ALU_LAT, 1, clock edges from operand presentation to valid acc/c/flags (legal range 1..15).
- NOP_OP, 8'h00, opcode treated as no-op: no ALU wait, no writeback.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr_op  in  8  ALU opcode
- instr_rd  in  3  destination register
- instr_ra  in  3  operand-a register
- instr_rb  in  3  operand-b register
- ld_en  in  1  direct register load strobe
- ld_addr  in  3  load address
- ld_data  in  16  load data
- alu_a  out  16  ALU operand a
- alu_b  out  16  ALU operand b
- alu_op  out  8  ALU opcode
- alu_cf  out  1  ALU carry-in (= cf_q)
- alu_acc  in  16  ALU primary result
- alu_c  in  16  ALU secondary/high result
- alu_c_flag  in  1  ALU carry
- alu_z_flag  in  1  ALU zero
- alu_o_flag  in  1  ALU overflow
- cf_q  out  1  latched carry flag
- zf_q  out  1  latched zero flag
- of_q  out  1  latched overflow flag
- hi_q  out  16  latched alu_c of last op
- done  out  1  one-cycle pulse: instruction retired
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational regfile read of dbg_addr

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - All 8 registers, hi_q, cf_q, zf_q and of_q are 0.
  - alu_a, alu_b and alu_op are 0; done is 0.
  - Assertion mid-operation aborts immediately; no writeback occurs.
- States: IDLE, WAIT, WB.
- instr_ready = (state==IDLE) & ~ld_en.
- IDLE:
  - If ld_en is high, regfile[ld_addr] <= ld_data at the edge; load has priority over instructions and no instruction is accepted that cycle.
  - Accept edge (instr_valid & instr_ready):
    - If instr_op == NOP_OP: stay IDLE and pulse done next cycle; no other state changes.
    - Otherwise: register alu_a <= reg[ra], alu_b <= reg[rb], alu_op <= instr_op; latch rd; set cnt <= ALU_LAT-1; go to WAIT.
- WAIT:
  - alu_a, alu_b, alu_op and alu_cf are held stable.
  - cnt decrements each edge; when cnt==0, go to WB.
  - ld_en is ignored outside IDLE (dropped, not queued).
- WB (one cycle; inputs sampled at the WB edge):
  - reg[rd] <= alu_acc; hi_q <= alu_c.
  - cf_q <= alu_c_flag; zf_q <= alu_z_flag; of_q <= alu_o_flag.
  - done <= 1; go to IDLE.
- Timing:
  - Accept at edge E: ALU sees new operands from E, and the writeback edge is E+ALU_LAT+1.
  - done is high for the single cycle after the writeback edge.
  - Next accept is possible at E+ALU_LAT+2.
- ra==rd or rb==rd: operands are read at accept, so old values are used; the result overwrites at WB.
- ra==rb is legal; both operands are the same value.
- alu_cf is always cf_q, so back-to-back carry chains use the previous instruction's carry.
- done is 0 in every cycle other than the retire pulse.
- dbg_data reflects the write in the cycle after the write edge; there is no bypass.
- All arithmetic lives in the ALU; the sequencer performs no width extension and no truncation.

Decomposition:
- Shared package `cpu_pkg`:
  - Opcode constants (NOP_OP and the ALU op encodings).
  - State enum {IDLE, WAIT, WB}.
  - REG_W=16, REG_N=8.
- One natural sub-module, `regfile_8x16`:
  - Synchronous write port.
  - Two combinational read ports plus the debug read port.
  - Async active-low clear.
- FSM and flag registers stay in alu_sequencer.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> all outputs 0, state IDLE; dbg_data for r0..r7 reads 0.
- Add with carry (bench ALU model: op 8'd2 = a+b+cf, registered, ALU_LAT=1):
  - Stimulus: load r1=10, r2=11, cf_q=0, then issue op=2, rd=3, ra=1, rb=2.
  - Required: r3=21, zf_q=0, cf_q=0, done pulses exactly 2 cycles after the accept cycle.
- Carry chain:
  - Stimulus: r1=16'hFFFF, r2=1; op=2 into r3, then op=2 with ra=r0 (0) and rb=r0 into r4.
  - Required: r3=0, cf_q=1, zf_q=1; then r4=1, cf_q=0.
- Overlap hazard:
  - Stimulus: op=2 with rd=ra=rb=1, r1=7, cf_q=0.
  - Required: r1=14; alu_a/alu_b stay 7 throughout WAIT.
- Handshake/priority:
  - Stimulus: ld_en and instr_valid high in the same IDLE cycle.
  - Required: load happens, instr_ready=0, instruction accepted next cycle. Also, ld_en during WAIT is ignored.
- NOP and latency sweep:
  - NOP: op=NOP_OP -> done next cycle, flags/regs unchanged.
  - Sweep: ALU_LAT=4 -> writeback at edge E+5, instr_ready low for 5 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode encodings and sequencer state codes
// for the 16-bit ALU issue/writeback stage.
package cpu_pkg;
    localparam int REG_W = 16;
    localparam int REG_N = 8;
    localparam int REG_A = $clog2(REG_N);
    typedef logic [REG_W-1:0] word_t;
    typedef logic [REG_A-1:0] raddr_t;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_ADC = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] WB   = 2'd2;
endpackage

// File: rtl/regfile_8x16.sv
// regfile_8x16: 8x16 register file with one synchronous write port,
// two combinational operand reads and a combinational debug read.
module regfile_8x16
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   we_i,
    input  raddr_t wa_i,
    input  word_t  wd_i,
    input  raddr_t ra_i,
    input  raddr_t rb_i,
    input  raddr_t dbg_i,
    output word_t  ra_o,
    output word_t  rb_o,
    output word_t  dbg_o
);
    word_t mem_q [REG_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign ra_o  = mem_q[ra_i];
    assign rb_o  = mem_q[rb_i];
    assign dbg_o = mem_q[dbg_i];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction at a time to an external ALU,
// waits ALU_LAT edges, then writes acc/c back and latches the flags.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter logic [7:0]  NOP_OP  = OP_NOP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr_op,
    input  raddr_t     instr_rd,
    input  raddr_t     instr_ra,
    input  raddr_t     instr_rb,
    input  logic       ld_en,
    input  raddr_t     ld_addr,
    input  word_t      ld_data,
    output word_t      alu_a,
    output word_t      alu_b,
    output logic [7:0] alu_op,
    output logic       alu_cf,
    input  word_t      alu_acc,
    input  word_t      alu_c,
    input  logic       alu_c_flag,
    input  logic       alu_z_flag,
    input  logic       alu_o_flag,
    output logic       cf_q,
    output logic       zf_q,
    output logic       of_q,
    output word_t      hi_q,
    output logic       done,
    input  raddr_t     dbg_addr,
    output word_t      dbg_data
);
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    raddr_t     rd_q, wa;
    word_t      rdata_a, rdata_b, wd;
    logic       accept, issue, we;

    assign instr_ready = (state_q == IDLE) && !ld_en;
    assign accept      = instr_valid && instr_ready;
    assign issue       = accept && (instr_op != NOP_OP);
    assign alu_cf      = cf_q;
    // The single write port is shared: writeback in WB, direct loads only in IDLE.
    assign we = (state_q == WB) || ((state_q == IDLE) && ld_en);
    assign wa = (state_q == WB) ? rd_q : ld_addr;
    assign wd = (state_q == WB) ? alu_acc : ld_data;

    always_comb begin
        state_d = (state_q == IDLE) ? (issue ? WAIT : IDLE)
                : (state_q == WAIT) ? ((cnt_q == '0) ? WB : WAIT)
                : IDLE;
        cnt_d   = issue ? LAT_M1 : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            hi_q    <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= (accept && !issue) || (state_q == WB);
            if (issue) begin
                alu_a  <= rdata_a;
                alu_b  <= rdata_b;
                alu_op <= instr_op;
                rd_q   <= instr_rd;
            end
            if (state_q == WB) begin
                hi_q <= alu_c;
                cf_q <= alu_c_flag;
                zf_q <= alu_z_flag;
                of_q <= alu_o_flag;
            end
        end
    end

    regfile_8x16 u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (we),
        .wa_i  (wa),
        .wd_i  (wd),
        .ra_i  (instr_ra),
        .rb_i  (instr_rb),
        .dbg_i (dbg_addr),
        .ra_o  (rdata_a),
        .rb_o  (rdata_b),
        .dbg_o (dbg_data)
    );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random checks of the sequencer against a
// register/flag model; a second instance covers ALU_LAT=4.
module tb_alu_sequencer;
    import cpu_pkg::*;

    typedef struct packed {
        logic [15:0] acc;
        logic [15:0] c;
        logic        cfl;
        logic        z;
        logic        o;
    } alu_res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0, instr_valid4 = 1'b0;
    logic [7:0]  instr_op = '0;
    logic [2:0]  instr_rd = '0, instr_ra = '0, instr_rb = '0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0, dbg_addr = '0;
    logic [15:0] ld_data = '0;

    logic        instr_ready, alu_cf, cf_q, zf_q, of_q, done;
    logic [15:0] alu_a, alu_b, hi_q, dbg_data;
    logic [7:0]  alu_op;
    logic        instr_ready4, alu_cf4, cf4, zf4, of4, done4;
    logic [15:0] alu_a4, alu_b4, hi4, dbg_data4;
    logic [7:0]  alu_op4;
    alu_res_t    alu1_q, alu4_q;

    int checks = 0, failures = 0;

    logic [15:0] m_reg [8];
    logic        m_cf, m_zf, m_of;
    logic [15:0] m_hi;
    logic [7:0]  p_op;
    logic [2:0]  p_rd;
    logic [15:0] p_a, p_b;
    alu_res_t    p_res;

    always #5 clk = ~clk;

    function automatic alu_res_t alu_f(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b, input logic cf);
        alu_res_t r;
        logic [16:0] s;
        logic [31:0] p;
        r = '0;
        case (op)
            OP_ADC: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, cf};
                r.acc = s[15:0]; r.c = a ^ b; r.cfl = s[16];
                r.o = (a[15] == b[15]) && (s[15] != a[15]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r.acc = s[15:0]; r.c = a & b; r.cfl = s[16];
                r.o = (a[15] != b[15]) && (s[15] != a[15]);
            end
            OP_MUL: begin
                p = 32'(a) * 32'(b);
                r.acc = p[15:0]; r.c = p[31:16]; r.o = |p[31:16];
            end
            default: begin
                r.acc = a | b;
            end
        endcase
        r.z = (r.acc == 16'd0);
        return r;
    endfunction

    // Registered bench ALUs; operands are held through WAIT, so one stage serves any latency.
    always @(posedge clk) begin
        alu1_q <= alu_f(alu_op, alu_a, alu_b, alu_cf);
        alu4_q <= alu_f(alu_op4, alu_a4, alu_b4, alu_cf4);
    end

    alu_sequencer #(.ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cf(alu_cf),
        .alu_acc(alu1_q.acc), .alu_c(alu1_q.c), .alu_c_flag(alu1_q.cfl),
        .alu_z_flag(alu1_q.z), .alu_o_flag(alu1_q.o),
        .cf_q(cf_q), .zf_q(zf_q), .of_q(of_q), .hi_q(hi_q), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu_sequencer #(.ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid4), .instr_ready(instr_ready4),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_cf(alu_cf4),
        .alu_acc(alu4_q.acc), .alu_c(alu4_q.c), .alu_c_flag(alu4_q.cfl),
        .alu_z_flag(alu4_q.z), .alu_o_flag(alu4_q.o),
        .cf_q(cf4), .zf_q(zf4), .of_q(of4), .hi_q(hi4), .done(done4),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_cf = 1'b0; m_zf = 1'b0; m_of = 1'b0; m_hi = '0;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
        m_reg[a] = d;
    endtask

    task automatic send(input logic [7:0] op, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
        int n = 0;
        while (!instr_ready && n < 20) begin step(); n++; end
        chk("ready", 16'(instr_ready), 16'd1);
        instr_valid = 1'b1; instr_op = op; instr_rd = d; instr_ra = a; instr_rb = b;
        p_op = op; p_rd = d; p_a = m_reg[a]; p_b = m_reg[b];
        p_res = alu_f(op, p_a, p_b, m_cf);
        step();
        instr_valid = 1'b0;
    endtask

    task automatic retire(input int lat);
        int n = 0;
        while (!done && n < 20) begin
            if (p_op != OP_NOP) begin
                chk("hold_a", alu_a, p_a);
                chk("hold_b", alu_b, p_b);
            end
            step();
            n++;
        end
        chk("latency", 16'(n), 16'(lat));
        if (p_op != OP_NOP) begin
            m_reg[p_rd] = p_res.acc; m_hi = p_res.c;
            m_cf = p_res.cfl; m_zf = p_res.z; m_of = p_res.o;
        end
        chk("cf", 16'(cf_q), 16'(m_cf));
        chk("zf", 16'(zf_q), 16'(m_zf));
        chk("of", 16'(of_q), 16'(m_of));
        chk("hi", hi_q, m_hi);
        rd_chk("wb_reg", p_rd, m_reg[p_rd]);
        step();
        chk("done_single", 16'(done), 16'd0);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_alu_a", alu_a, 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_ready", 16'(instr_ready), 16'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        load(3'd1, 16'd10);
        load(3'd2, 16'd11);
        send(OP_ADC, 3'd3, 3'd1, 3'd2);
        retire(2);
        rd_chk("add_r3", 3'd3, 16'd21);
        chk("add_zf", 16'(zf_q), 16'd0);
        chk("add_cf", 16'(cf_q), 16'd0);

        load(3'd1, 16'hFFFF);
        load(3'd2, 16'd1);
        send(OP_ADC, 3'd3, 3'd1, 3'd2);
        retire(2);
        rd_chk("chain_r3", 3'd3, 16'd0);
        chk("chain_cf", 16'(cf_q), 16'd1);
        chk("chain_zf", 16'(zf_q), 16'd1);
        send(OP_ADC, 3'd4, 3'd0, 3'd0);
        retire(2);
        rd_chk("chain_r4", 3'd4, 16'd1);
        chk("chain_cf2", 16'(cf_q), 16'd0);

        load(3'd1, 16'd7);
        send(OP_ADC, 3'd1, 3'd1, 3'd1);
        retire(2);
        rd_chk("overlap_r1", 3'd1, 16'd14);

        send(OP_NOP, 3'd2, 3'd1, 3'd1);
        retire(0);
        rd_chk("nop_r2", 3'd2, 16'd1);

        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h1234;
        instr_valid = 1'b1; instr_op = OP_ADC; instr_rd = 3'd6; instr_ra = 3'd5; instr_rb = 3'd5;
        #1 chk("ready_during_ld", 16'(instr_ready), 16'd0);
        step();
        ld_en = 1'b0;
        m_reg[5] = 16'h1234;
        rd_chk("ld_priority", 3'd5, 16'h1234);
        send(OP_ADC, 3'd6, 3'd5, 3'd5);
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'hBEEF;
        step();
        ld_en = 1'b0;
        retire(1);
        rd_chk("hs_r6", 3'd6, 16'h2468);
        rd_chk("ld_in_wait", 3'd7, 16'd0);

        load(3'd2, 16'h00F0);
        send(OP_MUL, 3'd5, 3'd5, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_alu_a2", alu_a, 16'd0);
        chk("rst_alu_b2", alu_b, 16'd0);
        chk("rst_alu_op2", 16'(alu_op), 16'd0);
        chk("rst_hi2", hi_q, 16'd0);
        chk("rst_flags2", 16'({cf_q, zf_q, of_q, done}), 16'd0);
        chk("rst_ready2", 16'(instr_ready), 16'd1);
        for (int i = 0; i < 8; i++) rd_chk("rst_reg", 3'(i), 16'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) load(3'(i), 16'($urandom));
        for (int k = 0; k < 30; k++) begin
            logic [7:0] op;
            op = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) load(3'($urandom_range(0, 7)), 16'($urandom));
            send(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            retire(op == OP_NOP ? 0 : 2);
        end

        load(3'd1, 16'd100);
        load(3'd2, 16'd200);
        instr_valid4 = 1'b1; instr_op = OP_ADC; instr_rd = 3'd3; instr_ra = 3'd1; instr_rb = 3'd2;
        step();
        instr_valid4 = 1'b0;
        begin
            int n = 0;
            while (!done4 && n < 30) begin
                chk("lat4_busy", 16'(instr_ready4), 16'd0);
                step();
                n++;
            end
            chk("lat4_latency", 16'(n), 16'd5);
        end
        chk("lat4_ready", 16'(instr_ready4), 16'd1);
        dbg_addr = 3'd3;
        #1 chk("lat4_r3", dbg_data4, 16'd300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
